mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the MINA2000 pipeline, directly downstream of the execute stage. It consumes the EX/MEM register contents (`mem_params_t`) and performs word loads and stores over a single-outstanding req/ack data bus. While a bus access is in progress it stalls the front of the pipeline. It owns the MEM/WB pipeline register and drives it with `wb_params_t`, so its output also serves as the MEM/WB forwarding source.

## Interface
- `BUS_TIMEOUT`, default 255: number of cycles an access may wait for `bus_ack` before it is aborted; legal range ≥1.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `mem_params`  in  `mem_params_t`  — from EX/MEM:
  - `rd_addr`, `rd_data` (ALU result or link value, also the effective address);
  - `mem_op` (`MEM_OP_NONE`/`MEM_OP_LOAD`/`MEM_OP_STORE`), `mem_data` (store data).
- `mem_valid`  in  1  — EX/MEM holds a real instruction, not a bubble.
- `stall`  out  1  — combinational; freezes IA, IF/ID, ID/EX and EX/MEM.
- `bus_req`  out  1  — access request; registered.
- `bus_we`  out  1  — 1 = store; registered.
- `bus_addr`  out  32  — word address `{rd_data[31:2],2'b00}`; registered.
- `bus_wdata`  out  32  — store data; registered; 0 for loads.
- `bus_rdata`  in  32  — load data, valid when `bus_ack`=1.
- `bus_ack`  in  1  — access complete.
- `bus_err`  out  1  — registered one-cycle pulse on timeout abort.
- `wb_params`  out  `wb_params_t`  — MEM/WB register (`rd_addr`, `rd_data`, `we`).
- `wb_valid`  out  1  — MEM/WB holds a real instruction.

## Operation
- Request phase:
  - The stage accepts a memory op when `mem_valid` is 1 and `mem_op` ≠ `MEM_OP_NONE`.
  - FSM states are `IDLE` and `BUS`; reset state is `IDLE`.
- `IDLE`:
  - With no memory op pending, the instruction completes through MEM/WB in one cycle: `wb.rd_data=mem_params.rd_data`, `wb.we=mem_valid`.
  - When a memory op is pending: assert `stall`, load `bus_req=1`, `bus_we`, `bus_addr` and `bus_wdata`, clear the timeout counter, and go to `BUS`.
- `BUS`:
  - Hold the bus outputs stable and increment the counter each cycle.
  - On `bus_ack`: drop `stall` combinationally in that cycle, go to `IDLE` with `bus_req=0`, and write MEM/WB:
    - load: `we=1`, `rd_data=bus_rdata`;
    - store: `we=0`.
  - On timeout (counter = `BUS_TIMEOUT-1` with no ack): behave as for an ack, but the load data is `32'h0` and `bus_err` pulses the next cycle.
  - `bus_ack` and timeout in the same cycle: the ack wins and `bus_err` stays 0.
- `stall` = (`IDLE` ∧ memory op pending) ∨ (`BUS` ∧ ¬`bus_ack` ∧ ¬timeout).
- MEM/WB register:
  - While `stall`=1 it loads a bubble (`wb_valid=0`, `we=0`), so no writeback is duplicated.
  - Otherwise `wb_valid<=mem_valid`.
- Other inputs:
  - `bus_ack` is ignored in `IDLE`.
  - Address bits [1:0] are discarded; there is no misalignment trap.
- Counter width is `$clog2(BUS_TIMEOUT+1)`; it never wraps because an abort occurs first.

## Timing
- Reset values (immediate on `rst_n` low, including in the middle of an access):
  - state `IDLE`, counter 0;
  - `bus_req`, `bus_we`, `bus_err`, `wb_valid` = 0;
  - `bus_addr`, `bus_wdata`, `wb_params` = 0.
- An outstanding access is abandoned on reset; a late `bus_ack` after reset is ignored.
- Non-memory instruction latency is 1 cycle (EX/MEM to MEM/WB).
- Memory ops:
  - The first `bus_req` cycle follows the acceptance cycle.
  - With an ack in the first `BUS` cycle, the op occupies MEM for 2 cycles (1 stall cycle).
  - Each additional ack-wait cycle adds 1 stall cycle.
  - The maximum occupancy is `BUS_TIMEOUT`+1 cycles.
- Back-to-back memory ops:
  - After an ack cycle, the next op enters `IDLE` on the following cycle.
  - `bus_req` is low for at least 1 cycle between accesses.
- Bus protocol: `bus_req` stays high until the ack or abort cycle inclusive and falls on the next edge; the address and data are stable throughout.

## Structure
- Package `types` gains:
  - `MEM_OP_LOAD` (if not already present);
  - `wb_params_t` (`rd_addr`, `rd_data` `u32_t`, `we`);
  - `mem_state_e` (`MEM_ST_IDLE`, `MEM_ST_BUS`).
- This is a single module with no sub-module. The FSM, timeout counter and MEM/WB register are small enough to keep together.

## Test plan
- ALU op (`mem_valid`=1, `MEM_OP_NONE`, `rd_data=32'h1234`, `rd_addr`=5) → next cycle `wb_valid`=1, `we`=1, `rd_data=32'h1234`, `stall` never asserted.
- Load from `rd_data=32'h103` with ack on the first `BUS` cycle and `bus_rdata=32'hCAFEBABE` → `bus_addr=32'h100`, `bus_we`=0, `stall` high for 1 cycle, then MEM/WB `we`=1, data `32'hCAFEBABE`, one bubble inserted before it.
- Store with `mem_data=32'hDEADBEEF` and ack delayed 3 cycles → `bus_wdata=32'hDEADBEEF` stable for 4 `bus_req` cycles, `stall` high for 4 cycles, MEM/WB `we`=0, `wb_valid`=1.
- `BUS_TIMEOUT`=4 with load and no ack → abort after 4 `BUS` cycles, `bus_err` pulses once, MEM/WB data 0; repeat with ack on the timeout cycle → data taken, `bus_err`=0.
- `rst_n` pulsed low mid-access, then `bus_ack` after release → all outputs 0 and state `IDLE`, the late ack is ignored, and the following ALU op completes normally.

Source files
------------

// File: rtl/types.sv
// Shared pipeline types for the MINA2000 EX/MEM and MEM/WB registers.
// Used by the memory stage and the stages around it.
package types;

    typedef logic [31:0] u32_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_e;

    typedef struct packed {
        reg_addr_t rd_addr;
        u32_t      rd_data;
        mem_op_e   mem_op;
        u32_t      mem_data;
    } mem_params_t;

    typedef struct packed {
        reg_addr_t rd_addr;
        u32_t      rd_data;
        logic      we;
    } wb_params_t;

    typedef enum logic {
        MEM_ST_IDLE,
        MEM_ST_BUS
    } mem_state_e;

    function automatic u32_t word_addr(input u32_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage.sv
// MEM stage: word loads/stores over a single-outstanding req/ack bus, owns MEM/WB.
// Latency: 1 cycle for non-memory ops, 2..BUS_TIMEOUT+1 cycles for loads/stores.
// Backpressure: combinational stall freezes the front end while an access is open.
module mem_stage
    import types::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  mem_params_t mem_params,
    input  logic        mem_valid,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output wb_params_t  wb_params,
    output logic        wb_valid
);

    localparam int             CW       = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BUS_TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          bus_err_q, bus_err_d;
    wb_params_t    wb_q, wb_d;
    logic          wb_valid_q, wb_valid_d;
    logic          stall_c;
    logic          mem_pending;
    logic          last_cycle;

    assign mem_pending = mem_valid && (mem_params.mem_op != MEM_OP_NONE);
    assign last_cycle  = bus_ack || (cnt_q == CNT_LAST);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bus_req_d        = bus_req_q;
        bus_we_d         = bus_we_q;
        bus_addr_d       = bus_addr_q;
        bus_wdata_d      = bus_wdata_q;
        bus_err_d        = 1'b0;
        stall_c          = 1'b0;
        wb_valid_d       = mem_valid;
        wb_d.rd_addr     = mem_params.rd_addr;
        wb_d.rd_data     = mem_params.rd_data;
        wb_d.we          = mem_valid;

        if (state_q == MEM_ST_IDLE) begin
            if (mem_pending) begin
                stall_c     = 1'b1;
                state_d     = MEM_ST_BUS;
                cnt_d       = '0;
                bus_req_d   = 1'b1;
                bus_we_d    = (mem_params.mem_op == MEM_OP_STORE);
                bus_addr_d  = word_addr(mem_params.rd_data);
                bus_wdata_d = (mem_params.mem_op == MEM_OP_STORE) ? mem_params.mem_data : '0;
            end
        end else begin
            if (last_cycle) begin
                // An ack on the timeout cycle still counts as a successful access.
                state_d   = MEM_ST_IDLE;
                bus_req_d = 1'b0;
                bus_err_d = !bus_ack;
                wb_d.we   = !bus_we_q;
                if (!bus_we_q) begin
                    wb_d.rd_data = bus_ack ? bus_rdata : '0;
                end
            end else begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end

        if (stall_c) begin
            wb_valid_d = 1'b0;
            wb_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MEM_ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            wb_q        <= '0;
            wb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            wb_q        <= wb_d;
            wb_valid_q  <= wb_valid_d;
        end
    end

    assign stall     = stall_c;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign wb_params = wb_q;
    assign wb_valid  = wb_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction is expanded into a per-cycle
// expectation timeline from its bus outcome, checked every cycle by one compare process.
module tb_mem_stage;
    import types::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    mem_params_t mem_params;
    logic        mem_valid;
    logic        stall, bus_req, bus_we, bus_err, wb_valid, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    wb_params_t  wb_params;

    mem_stage #(.BUS_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .mem_params(mem_params), .mem_valid(mem_valid),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .wb_params(wb_params), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, req, we, err, wbv, wbwe;
        logic [4:0]  wra;
        logic [31:0] addr, wdata, wrd;
    } exp_t;

    exp_t        expq[$];
    exp_t        prev;
    logic        chk_en = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t base();
        exp_t e;
        e.stall = 1'b0; e.req = m_req; e.we = m_we; e.addr = m_addr; e.wdata = m_wdata;
        e.err = 1'b0; e.wbv = 1'b0; e.wbwe = 1'b0; e.wra = '0; e.wrd = '0;
        return e;
    endfunction

    // Combinational stall checked against this cycle, registered outputs against last cycle.
    always @(negedge clk) begin
        if (chk_en && expq.size() != 0) begin
            exp_t cur;
            cur = expq.pop_front();
            chk("stall", stall, cur.stall);
            chk("bus_req", bus_req, prev.req);
            chk("bus_we", bus_we, prev.we);
            chk("bus_addr", bus_addr, prev.addr);
            chk("bus_wdata", bus_wdata, prev.wdata);
            chk("bus_err", bus_err, prev.err);
            chk("wb_valid", wb_valid, prev.wbv);
            chk("wb_we", wb_params.we, prev.wbwe);
            if (prev.wbv) chk("wb_rd_addr", wb_params.rd_addr, prev.wra);
            if (prev.wbv && prev.wbwe) chk("wb_rd_data", wb_params.rd_data, prev.wrd);
            prev = cur;
        end
    end

    task automatic cyc(input exp_t e);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic v, input mem_op_e op, input logic [4:0] ra, input logic [31:0] rd);
        exp_t e;
        mem_valid = v;
        mem_params.rd_addr = ra; mem_params.rd_data = rd;
        mem_params.mem_op = op;  mem_params.mem_data = $urandom;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        e = base();
        e.wbv = v; e.wbwe = v; e.wra = ra; e.wrd = rd;
        cyc(e);
    endtask

    // d = ack delay in BUS cycles; d >= T means the ack never comes in time.
    task automatic mem_op(input logic st, input logic [4:0] ra, input logic [31:0] rd,
                          input logic [31:0] md, input int d, input logic [31:0] rdata);
        exp_t e;
        logic ackd;
        int   nb;
        mem_valid = 1'b1;
        mem_params.rd_addr = ra; mem_params.rd_data = rd;
        mem_params.mem_op = st ? MEM_OP_STORE : MEM_OP_LOAD; mem_params.mem_data = md;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        m_req = 1'b1; m_we = st; m_addr = rd & 32'hFFFF_FFFC; m_wdata = st ? md : 32'h0;
        e = base(); e.stall = 1'b1;
        cyc(e);
        ackd = (d < T);
        nb   = ackd ? d + 1 : T;
        for (int k = 1; k <= nb; k++) begin
            bus_ack = 1'b0; bus_rdata = $urandom;
            if (k == nb) begin
                bus_ack = ackd;
                if (ackd) bus_rdata = rdata;
                m_req = 1'b0;
                e = base();
                e.err = !ackd; e.wbv = 1'b1; e.wbwe = !st; e.wra = ra;
                e.wrd = ackd ? rdata : 32'h0;
            end else begin
                e = base(); e.stall = 1'b1;
            end
            cyc(e);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        prev = base();
    endtask

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_params = '0; bus_ack = 1'b0; bus_rdata = '0;
        model_reset();
        #2;
        chk("rst_bus_req", bus_req, 0); chk("rst_bus_addr", bus_addr, 0);
        chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_params", 32'(wb_params), 0);
        chk("rst_stall", stall, 0); chk("rst_bus_err", bus_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        alu_op(1'b1, MEM_OP_NONE, 5'd5, 32'h1234);
        chk("lit_alu_valid", wb_valid, 1); chk("lit_alu_data", wb_params.rd_data, 32'h1234);
        chk("lit_alu_addr", wb_params.rd_addr, 5);
        mem_op(1'b0, 5'd7, 32'h103, 32'h0, 0, 32'hCAFEBABE);
        chk("lit_ld_addr", bus_addr, 32'h100); chk("lit_ld_data", wb_params.rd_data, 32'hCAFEBABE);
        mem_op(1'b1, 5'd3, 32'h2000, 32'hDEADBEEF, 3, 32'h0);
        chk("lit_st_wdata", bus_wdata, 32'hDEADBEEF); chk("lit_st_we", wb_params.we, 0);
        chk("lit_st_valid", wb_valid, 1); chk("lit_st_err", bus_err, 0);
        mem_op(1'b0, 5'd9, 32'h40, 32'h0, 99, 32'h0);
        chk("lit_to_err", bus_err, 1); chk("lit_to_data", wb_params.rd_data, 0);
        mem_op(1'b0, 5'd10, 32'h44, 32'h0, T - 1, 32'h5A5A_0001);
        chk("lit_tack_err", bus_err, 0); chk("lit_tack_data", wb_params.rd_data, 32'h5A5A_0001);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic v;
                v = 1'($urandom);
                alu_op(v, v ? MEM_OP_NONE : mem_op_e'($urandom_range(0, 2)),
                       5'($urandom), $urandom);
            end else begin
                mem_op(1'($urandom), 5'($urandom), $urandom, $urandom,
                       $urandom_range(0, T + 1), $urandom);
            end
        end
        alu_op(1'b0, MEM_OP_NONE, 5'd0, 32'h0);

        // Reset in the middle of an access, then a stale ack.
        chk_en = 1'b0;
        expq.delete();
        mem_valid = 1'b1; mem_params.mem_op = MEM_OP_LOAD; mem_params.rd_data = 32'h88;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("mid_bus_req", bus_req, 1);
        mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus_req, 0); chk("mid_rst_addr", bus_addr, 0);
        chk("mid_rst_valid", wb_valid, 0); chk("mid_rst_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        chk("late_ack_req", bus_req, 0); chk("late_ack_valid", wb_valid, 0);
        chk("late_ack_err", bus_err, 0);
        model_reset();
        chk_en = 1'b1;
        alu_op(1'b1, MEM_OP_NONE, 5'd12, 32'h7777);
        chk("post_rst_data", wb_params.rd_data, 32'h7777);
        alu_op(1'b0, MEM_OP_NONE, 5'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
